// File: rtl/wash_cycle_ctrl.sv
// Wash-cycle sequencer: SOAK, N x (WASH, RINSE), SPIN, with lid pause and abort-to-drain.
// state | meaning
// IDLE  | waiting for coin with lid closed
// SOAK  | pre-soak, once per run
// WASH  | wash phase of pass pass_idx
// RINSE | rinse phase of pass pass_idx
// SPIN  | final spin, done pulses on exit
// DRAIN | abort drain, ignores lid, aborted pulses on exit
module wash_cycle_ctrl #(
    parameter int CNT_W      = 8,
    parameter int SOAK_T     = 4,
    parameter int WASH_T     = 4,
    parameter int RINSE_T    = 3,
    parameter int SPIN_T     = 3,
    parameter int DRAIN_T    = 2,
    parameter int PASS_W     = 2,
    parameter int MAX_PASSES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coin,
    input  logic [PASS_W-1:0] passes,
    input  logic              lid_open,
    input  logic              abort,
    output logic [2:0]        state_o,
    output logic              busy,
    output logic              paused,
    output logic [CNT_W-1:0]  time_left,
    output logic [PASS_W-1:0] pass_idx,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SOAK  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  SOAK_L  = CNT_W'(SOAK_T - 1);
    localparam logic [CNT_W-1:0]  WASH_L  = CNT_W'(WASH_T - 1);
    localparam logic [CNT_W-1:0]  RINSE_L = CNT_W'(RINSE_T - 1);
    localparam logic [CNT_W-1:0]  SPIN_L  = CNT_W'(SPIN_T - 1);
    localparam logic [CNT_W-1:0]  DRAIN_L = CNT_W'(DRAIN_T - 1);
    localparam logic [PASS_W-1:0] MAX_P   = PASS_W'(MAX_PASSES);
    localparam logic [PASS_W:0]   MAX_X   = (PASS_W + 1)'(MAX_PASSES);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tl_q, tl_d;
    logic [PASS_W-1:0] pidx_q, pidx_d;
    logic [PASS_W-1:0] n_q, n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              active;
    logic [PASS_W:0]   passes_x;
    logic [PASS_W-1:0] n_start;

    // passes=0 still runs one pass; anything above the clamp runs MAX_PASSES
    assign passes_x = {1'b0, passes};
    assign n_start  = (passes == '0) ? PASS_W'(1) :
                      (passes_x > MAX_X) ? MAX_P : passes;

    assign active = (state_q == S_SOAK) || (state_q == S_WASH) ||
                    (state_q == S_RINSE) || (state_q == S_SPIN);

    always_comb begin
        state_d   = state_q;
        tl_d      = tl_q;
        pidx_d    = pidx_q;
        n_d       = n_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (coin && !lid_open) begin
                    state_d = S_SOAK;
                    tl_d    = SOAK_L;
                    pidx_d  = '0;
                    n_d     = n_start;
                end
            end
            S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
                // abort outranks both the lid pause and a phase ending this cycle
                if (abort) begin
                    state_d = S_DRAIN;
                    tl_d    = DRAIN_L;
                end else if (!lid_open) begin
                    if (tl_q != '0) begin
                        tl_d = tl_q - CNT_W'(1);
                    end else begin
                        case (state_q)
                            S_SOAK: begin
                                state_d = S_WASH;
                                tl_d    = WASH_L;
                            end
                            S_WASH: begin
                                state_d = S_RINSE;
                                tl_d    = RINSE_L;
                            end
                            S_RINSE: begin
                                if (pidx_q != n_q - PASS_W'(1)) begin
                                    state_d = S_WASH;
                                    tl_d    = WASH_L;
                                    pidx_d  = pidx_q + PASS_W'(1);
                                end else begin
                                    state_d = S_SPIN;
                                    tl_d    = SPIN_L;
                                end
                            end
                            default: begin
                                state_d = S_IDLE;
                                tl_d    = '0;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_DRAIN: begin
                if (tl_q != '0) begin
                    tl_d = tl_q - CNT_W'(1);
                end else begin
                    state_d   = S_IDLE;
                    tl_d      = '0;
                    aborted_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tl_d    = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tl_q      <= '0;
            pidx_q    <= '0;
            n_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tl_q      <= tl_d;
            pidx_q    <= pidx_d;
            n_q       <= n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign state_o   = state_q;
    assign busy      = busy_q;
    assign paused    = active && lid_open;
    assign time_left = tl_q;
    assign pass_idx  = pidx_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: per-cycle expected outputs from a phase-schedule model go through
// a queue to an independent monitor; directed runs also count busy/done/aborted cycles.
module tb_wash_cycle_ctrl;

    localparam int SOAK_T  = 4;
    localparam int WASH_T  = 4;
    localparam int RINSE_T = 3;
    localparam int SPIN_T  = 3;
    localparam int DRAIN_T = 2;
    localparam int MAXP    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin = 1'b0;
    logic [1:0] passes = 2'd0;
    logic       lid_open = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] state_o;
    logic       busy, paused, done, aborted;
    logic [7:0] time_left;
    logic [1:0] pass_idx;

    always #5 clk = ~clk;

    wash_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .coin(coin), .passes(passes),
        .lid_open(lid_open), .abort(abort), .state_o(state_o), .busy(busy),
        .paused(paused), .time_left(time_left), .pass_idx(pass_idx),
        .done(done), .aborted(aborted)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       busy;
        logic       paused;
        logic [7:0] tl;
        logic [1:0] pidx;
        logic       done;
        logic       ab;
    } obs_t;

    typedef struct {
        int st;
        int len;
        int pass;
    } phase_t;

    obs_t   exp_q[$];
    phase_t sched[$];
    bit     m_act, m_drain, m_done, m_ab;
    int     m_ph, m_el, m_last_pass;
    int     n_tests = 0;
    int     n_fail = 0;
    int     cyc = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        m_act = 0; m_drain = 0; m_done = 0; m_ab = 0;
        m_ph = 0; m_el = 0; m_last_pass = 0;
    endtask

    // a run is a list of (phase, length, pass) segments consumed one unpaused cycle at a time
    task automatic model_start(input int n);
        sched.delete();
        sched.push_back(phase_t'{1, SOAK_T, 0});
        for (int k = 0; k < n; k++) begin
            sched.push_back(phase_t'{2, WASH_T, k});
            sched.push_back(phase_t'{3, RINSE_T, k});
        end
        sched.push_back(phase_t'{4, SPIN_T, n - 1});
        m_act = 1; m_drain = 0; m_ph = 0; m_el = 0;
    endtask

    function automatic obs_t model_obs(input logic lid);
        obs_t o;
        o = '0;
        o.busy = m_act;
        o.done = m_done;
        o.ab   = m_ab;
        if (m_act) begin
            o.st     = 3'(sched[m_ph].st);
            o.tl     = 8'(sched[m_ph].len - 1 - m_el);
            o.pidx   = 2'(sched[m_ph].pass);
            o.paused = !m_drain && lid;
        end else begin
            o.pidx = 2'(m_last_pass);
        end
        return o;
    endfunction

    task automatic model_step(input logic c, input logic l, input logic a, input logic [1:0] p);
        int n;
        m_done = 0;
        m_ab   = 0;
        if (!m_act) begin
            if (c && !l) begin
                n = (p == 0) ? 1 : ((int'(p) > MAXP) ? MAXP : int'(p));
                model_start(n);
            end
        end else if (m_drain) begin
            m_el++;
            if (m_el == sched[0].len) begin
                m_last_pass = sched[0].pass;
                m_act = 0;
                m_ab  = 1;
            end
        end else if (a) begin
            int pp;
            pp = sched[m_ph].pass;
            sched.delete();
            sched.push_back(phase_t'{5, DRAIN_T, pp});
            m_ph = 0; m_el = 0; m_drain = 1;
        end else if (!l) begin
            m_el++;
            if (m_el == sched[m_ph].len) begin
                m_el = 0;
                if (m_ph == sched.size() - 1) begin
                    m_last_pass = sched[m_ph].pass;
                    m_act  = 0;
                    m_done = 1;
                end else begin
                    m_ph++;
                end
            end
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic drive_cycle(input logic c, input logic l, input logic a,
                               input logic [1:0] p, input logic r);
        coin = c; lid_open = l; abort = a; passes = p; rst_n = r;
        if (!r) model_reset();
        #1;
        exp_q.push_back(model_obs(l));
        if (r) model_step(c, l, a, p);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        obs_t e, g;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {state_o, busy, paused, time_left, pass_idx, done, aborted};
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc %0d: got st=%0d busy=%0b paused=%0b tl=%0d pidx=%0d done=%0b ab=%0b, want st=%0d busy=%0b paused=%0b tl=%0d pidx=%0d done=%0b ab=%0b",
                             cyc, g.st, g.busy, g.paused, g.tl, g.pidx, g.done, g.ab,
                             e.st, e.busy, e.paused, e.tl, e.pidx, e.done, e.ab);
                end
            end
        end
    end

    // mode 0 plain, 1 lid open 5 cycles at WASH tl=2, 2 abort in first RINSE plus coin in DRAIN,
    // 3 reset pulse on the first SPIN cycle
    task automatic run_dir(input string nm, input logic [1:0] p, input int mode,
                           input int exp_busy, input int exp_done, input int exp_ab);
        int nb, nd, na, lid_left;
        bit trig;
        logic c, l, a, r;
        nb = 0; nd = 0; na = 0; lid_left = 0; trig = 0;
        drive_cycle(1'b1, 1'b0, 1'b0, p, 1'b1);
        for (int i = 0; i < 40; i++) begin
            c = 0; l = 0; a = 0; r = 1;
            if (mode == 1 && !trig && state_o == 3'd2 && time_left == 8'd2) begin
                trig = 1;
                lid_left = 5;
            end
            if (lid_left > 0) begin
                l = 1;
                lid_left--;
            end
            if (mode == 2 && !trig && state_o == 3'd3) begin
                trig = 1; a = 1; l = 1;
            end
            if (mode == 2 && state_o == 3'd5) c = 1;
            if (mode == 3 && !trig && state_o == 3'd4) begin
                trig = 1;
                r = 0;
            end
            nb += int'(busy);
            nd += int'(done);
            na += int'(aborted);
            drive_cycle(c, l, a, p, r);
        end
        check({nm, " busy cycles"}, nb, exp_busy);
        check({nm, " done pulses"}, nd, exp_done);
        check({nm, " aborted pulses"}, na, exp_ab);
    endtask

    initial begin
        bit   lid_r;
        logic c, a, r;
        logic [1:0] p;
        model_reset();
        @(negedge clk);
        drive_cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("reset state", int'(state_o), 0);
        check("reset time_left", int'(time_left), 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        run_dir("single", 2'd1, 0, 14, 1, 0);
        run_dir("multi", 2'd2, 0, 21, 1, 0);
        run_dir("clamp0", 2'd0, 0, 14, 1, 0);
        run_dir("three", 2'd3, 0, 28, 1, 0);
        run_dir("lid", 2'd1, 1, 19, 1, 0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        check("coin with lid open", int'(busy), 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
        run_dir("abort", 2'd1, 2, 11, 0, 1);
        run_dir("reset spin", 2'd1, 3, 12, 0, 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
        run_dir("after reset", 2'd1, 0, 14, 1, 0);

        lid_r = 0;
        for (int i = 0; i < 4000; i++) begin
            c = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) lid_r = !lid_r;
            a = ($urandom_range(0, 49) == 0);
            p = 2'($urandom_range(0, 3));
            r = !($urandom_range(0, 299) == 0);
            drive_cycle(c, lid_r, a, p, r);
        end

        drive_cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        #3;
        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
